// File: rtl/word_assembler_if.sv
// Byte-in / word-out bundle between a byte source, the word assembler and a holding register.
// The assembler uses the slave modport; the byte source and the register side use master.
interface word_assembler_if #(
    parameter int unsigned WORD_W = 32
);
    logic              byte_valid;
    logic              byte_ready;
    logic [7:0]        byte_data;
    logic              flush;
    logic              word_load;
    logic [WORD_W-1:0] word_out;
    logic              word_partial;
    logic [2:0]        byte_count;
    logic              timeout_err;

    modport master (
        output byte_valid, byte_data, flush,
        input  byte_ready, word_load, word_out, word_partial, byte_count, timeout_err
    );

    modport slave (
        input  byte_valid, byte_data, flush,
        output byte_ready, word_load, word_out, word_partial, byte_count, timeout_err
    );
endinterface

// File: rtl/word_assembler.sv
// Packs a byte stream into WORD_BYTES-wide words and emits one-cycle load pulses for a holding register.
// Optional partial-word timeout is compiled in with `define WORD_ASM_TIMEOUT_EN.
module word_assembler #(
    parameter int unsigned WORD_BYTES    = 4,
    parameter bit          LITTLE_ENDIAN = 1'b1,
    parameter int unsigned TIMEOUT_CYC   = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    word_assembler_if.slave   bus
);
    localparam int unsigned WORD_W = 8 * WORD_BYTES;

    if (WORD_BYTES < 2 || WORD_BYTES > 4 || TIMEOUT_CYC == 0) begin : g_param_check
        $error("word_assembler: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] merged;
    logic              load_q, load_d;
    logic              part_q, part_d;
    logic              tmo_q, tmo_d;
    logic              accept;
    logic              full;
    logic              expire;
    logic [2:0]        cnt_inc;
    logic [2:0]        lane;

    // Ready depends on state only so the source never sees a combinational loop through valid.
    assign bus.byte_ready = (state_q != EMIT);
    assign accept         = bus.byte_valid & bus.byte_ready;
    assign cnt_inc        = cnt_q + 3'(accept);
    assign full           = (cnt_inc == 3'(WORD_BYTES));
    assign lane           = LITTLE_ENDIAN ? cnt_q : (3'(WORD_BYTES - 1) - cnt_q);

    always_comb begin
        merged = acc_q;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (accept && (lane == 3'(i))) begin
                merged[i*8 +: 8] = bus.byte_data;
            end
        end
    end

`ifdef WORD_ASM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] idle_q, idle_d;

    assign expire = (state_q == FILL) && !accept && (idle_q == TO_W'(TIMEOUT_CYC - 1));

    // Counts FILL cycles without an accept; anything that leaves FILL or takes a byte restarts it.
    always_comb begin
        idle_d = '0;
        if (state_q == FILL && !accept && !bus.flush && !expire) begin
            idle_d = idle_q + TO_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        word_d  = word_q;
        part_d  = part_q;
        load_d  = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FILL;
                    cnt_d   = cnt_inc;
                    acc_d   = merged;
                end
            end
            FILL: begin
                // A completing byte wins over flush, and flush wins over a timeout in the same cycle.
                if (full || bus.flush) begin
                    state_d = EMIT;
                    word_d  = merged;
                    part_d  = !full;
                    load_d  = 1'b1;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_inc;
                    acc_d = merged;
                end else if (expire) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                    tmo_d   = 1'b1;
                end
            end
            EMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            word_q  <= '0;
            part_q  <= 1'b0;
            load_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            part_q  <= part_d;
            load_q  <= load_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.word_load    = load_q;
    assign bus.word_out     = word_q;
    assign bus.word_partial = part_q;
    assign bus.byte_count   = cnt_q;
    assign bus.timeout_err  = tmo_q;
endmodule

// File: tb/tb_word_assembler.sv
// Self-checking bench for word_assembler: per-cycle vector table on a little-endian instance,
// plus hand-written sequences for big-endian streaming, mid-word reset and the partial-word timeout.
module tb_word_assembler;
    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    word_assembler_if #(.WORD_W(32)) if_le ();
    word_assembler_if #(.WORD_W(32)) if_be ();

    word_assembler #(.WORD_BYTES(4), .LITTLE_ENDIAN(1'b1), .TIMEOUT_CYC(8)) u_le (
        .Clk(Clk), .Reset(Reset), .bus(if_le)
    );
    word_assembler #(.WORD_BYTES(4), .LITTLE_ENDIAN(1'b0), .TIMEOUT_CYC(8)) u_be (
        .Clk(Clk), .Reset(Reset), .bus(if_be)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic        ld;
        logic [31:0] w;
        logic        p;
        logic        rdy;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic f, logic ld, logic [31:0] w,
                                logic p, logic rdy, logic [2:0] cnt);
        vec_t r;
        r.v = v; r.d = d; r.f = f; r.ld = ld; r.w = w; r.p = p; r.rdy = rdy; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle on the little-endian instance and land 1 time unit after the edge.
    task automatic send(input logic v, input logic [7:0] d, input logic f);
        if_le.byte_valid = v;
        if_le.byte_data  = d;
        if_le.flush      = f;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  bq [8];
        logic [31:0] words [2];
        logic        acc;
        int          idx, pulses, last, loads, tmos;
        logic [37:0] act, exp;

        if_le.byte_valid = 1'b0; if_le.byte_data = 8'h00; if_le.flush = 1'b0;
        if_be.byte_valid = 1'b0; if_be.byte_data = 8'h00; if_be.flush = 1'b0;

        // Reset state of both instances
        #2;
        check("reset_le", {if_le.word_out, if_le.word_load, if_le.word_partial, if_le.timeout_err,
                           if_le.byte_count}, 64'h0);
        check("reset_be", {if_be.word_out, if_be.word_load, if_be.word_partial, if_be.timeout_err,
                           if_be.byte_count}, 64'h0);
        #20;
        Reset = 1'b0;
        #1;
        check("ready_after_reset", {if_le.byte_ready, if_be.byte_ready}, 64'h3);
        @(posedge Clk);
        #1;

        // T1/T3/T6 table: outputs expected after the edge that consumes each vector's inputs
        vecs.push_back(mk(1, 8'h11, 0, 0, 32'h0000_0000, 0, 1, 1));
        vecs.push_back(mk(1, 8'h22, 0, 0, 32'h0000_0000, 0, 1, 2));
        vecs.push_back(mk(1, 8'h33, 0, 0, 32'h0000_0000, 0, 1, 3));
        vecs.push_back(mk(1, 8'h44, 0, 1, 32'h4433_2211, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 32'h4433_2211, 0, 1, 0));
        vecs.push_back(mk(1, 8'hAA, 0, 0, 32'h4433_2211, 0, 1, 1));
        vecs.push_back(mk(1, 8'hBB, 0, 0, 32'h4433_2211, 0, 1, 2));
        vecs.push_back(mk(0, 8'h00, 1, 1, 32'h0000_BBAA, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 32'h0000_BBAA, 0, 1, 0));
        vecs.push_back(mk(1, 8'h11, 0, 0, 32'h0000_BBAA, 0, 1, 1));
        vecs.push_back(mk(1, 8'h22, 0, 0, 32'h0000_BBAA, 0, 1, 2));
        vecs.push_back(mk(1, 8'h33, 0, 0, 32'h0000_BBAA, 0, 1, 3));
        vecs.push_back(mk(1, 8'hCC, 1, 1, 32'hCC33_2211, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 32'hCC33_2211, 0, 1, 0));
        vecs.push_back(mk(1, 8'h55, 0, 0, 32'hCC33_2211, 0, 1, 1));
        vecs.push_back(mk(1, 8'h66, 1, 1, 32'h0000_6655, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 32'h0000_6655, 0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 32'h0000_6655, 0, 1, 0));
        vecs.push_back(mk(1, 8'h77, 0, 0, 32'h0000_6655, 0, 1, 1));
        vecs.push_back(mk(1, 8'h88, 0, 0, 32'h0000_6655, 0, 1, 2));
        vecs.push_back(mk(1, 8'h99, 0, 0, 32'h0000_6655, 0, 1, 3));
        vecs.push_back(mk(1, 8'hAB, 0, 1, 32'hAB99_8877, 0, 0, 0));
        vecs.push_back(mk(1, 8'hCD, 0, 0, 32'hAB99_8877, 0, 1, 0));
        vecs.push_back(mk(1, 8'hCD, 0, 0, 32'hAB99_8877, 0, 1, 1));
        vecs.push_back(mk(1, 8'hEF, 0, 0, 32'hAB99_8877, 0, 1, 2));
        vecs.push_back(mk(1, 8'h01, 0, 0, 32'hAB99_8877, 0, 1, 3));
        vecs.push_back(mk(1, 8'h02, 0, 1, 32'h0201_EFCD, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 32'h0201_EFCD, 0, 1, 0));

        foreach (vecs[i]) begin
            send(vecs[i].v, vecs[i].d, vecs[i].f);
            act = {if_le.word_load, if_le.word_out, (vecs[i].ld ? if_le.word_partial : 1'b0),
                   if_le.byte_ready, if_le.byte_count};
            exp = {vecs[i].ld, vecs[i].w, vecs[i].p, vecs[i].rdy, vecs[i].cnt};
            check($sformatf("vec%0d {load,word,partial,ready,count}", i), 64'(act), 64'(exp));
        end
        send(0, 8'h00, 0);

        // T2: big-endian instance, 8 bytes under continuous valid
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        idx = 0; pulses = 0; last = 0;
        words[0] = 32'h0; words[1] = 32'h0;
        for (int c = 1; c <= 14; c++) begin
            if_be.byte_valid = (idx < 8);
            if (idx < 8) if_be.byte_data = bq[idx];
            acc = if_be.byte_valid && if_be.byte_ready;
            @(posedge Clk);
            #1;
            if (acc) idx++;
            if (if_be.word_load) begin
                if (pulses < 2) words[pulses] = if_be.word_out;
                pulses++;
                last = c + 1;
            end
        end
        if_be.byte_valid = 1'b0;
        check("be_pulses", 64'(pulses), 64'd2);
        check("be_last_emit_cycle", 64'(last), 64'd10);
        check("be_word0", 64'(words[0]), 64'h1122_3344);
        check("be_word1", 64'(words[1]), 64'h5566_7788);
        check("be_bytes_taken", 64'(idx), 64'd8);

        // T4: reset mid-word discards the partial word
        send(1, 8'hA1, 0);
        send(1, 8'hA2, 0);
        if_le.byte_valid = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("midreset_async", {if_le.word_out, if_le.word_load, if_le.byte_count}, 64'h0);
        #3;
        Reset = 1'b0;
        loads = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk);
            #1;
            if (if_le.word_load) loads++;
        end
        check("midreset_no_load", 64'(loads), 64'd0);
        check("midreset_state", {if_le.word_out, if_le.byte_ready, if_le.byte_count},
              {31'h0, 33'h0_0000_0008});
        send(1, 8'h01, 0);
        send(1, 8'h02, 0);
        send(1, 8'h03, 0);
        send(1, 8'h04, 0);
        check("after_reset_word", {if_le.word_load, if_le.word_partial, if_le.word_out},
              {30'h0, 2'b10, 32'h0403_0201});
        send(0, 8'h00, 0);

        // T5: single byte then idle
        send(1, 8'h5A, 0);
        if_le.byte_valid = 1'b0;
        loads = 0; tmos = 0;
`ifdef WORD_ASM_TIMEOUT_EN
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk);
            #1;
            if (if_le.word_load) loads++;
            if (if_le.timeout_err) tmos++;
        end
        check("timeout_pulses", 64'(tmos), 64'd1);
        check("timeout_no_load", 64'(loads), 64'd0);
        check("timeout_count", 64'(if_le.byte_count), 64'd0);
`else
        for (int c = 0; c < 1000; c++) begin
            @(posedge Clk);
            #1;
            if (if_le.word_load) loads++;
            if (if_le.timeout_err) tmos++;
        end
        check("hold_no_timeout", 64'(tmos), 64'd0);
        check("hold_no_load", 64'(loads), 64'd0);
        check("hold_count", 64'(if_le.byte_count), 64'd1);
        send(0, 8'h00, 1);
        check("hold_flush_word", {if_le.word_load, if_le.word_partial, if_le.word_out},
              {30'h0, 2'b11, 32'h0000_005A});
`endif
        send(0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
